// File: rtl/vga_layer_mixer.sv
// Two-stage VGA pixel compositor: fixed-priority layer merge with per-layer modes,
// frame-synchronous blinking, visible-area blanking and sync delay matching.
module vga_layer_mixer #(
  parameter int                 LAYERS       = 4,
  parameter int                 COLOR_W      = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 8'b010_010_01,
  parameter int                 BLINK_FRAMES = 16,
  parameter logic               SYNC_IDLE    = 1'b1
) (
  input  logic                        mclk,
  input  logic                        reset,
  input  logic                        von,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        refresh,
  input  logic [LAYERS*COLOR_W-1:0]   layer_color,
  input  logic [LAYERS-1:0]           layer_valid,
  input  logic [2*LAYERS-1:0]         layer_mode,
  output logic [COLOR_W-1:0]          out_color,
  output logic                        HSYNC,
  output logic                        VSYNC,
  output logic                        out_von,
  output logic                        blink_phase
);

  localparam int               CNT_W    = $clog2(BLINK_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  localparam logic [1:0] MODE_INVERT  = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_DISABLE = 2'b11;

  logic                      s1Von_q;
  logic                      s1Hsync_q;
  logic                      s1Vsync_q;
  logic [LAYERS*COLOR_W-1:0] s1Color_q;
  logic [LAYERS-1:0]         s1Valid_q;
  logic [2*LAYERS-1:0]       s1Mode_q;

  logic [COLOR_W-1:0]        outColor_q;
  logic [COLOR_W-1:0]        outColor_d;
  logic                      outHsync_q;
  logic                      outVsync_q;
  logic                      outVon_q;

  logic [CNT_W-1:0]          blinkCnt_q;
  logic [CNT_W-1:0]          blinkCnt_d;
  logic                      blinkPhase_q;
  logic                      blinkPhase_d;

  logic [LAYERS-1:0]         layerEffective;
  logic [COLOR_W-1:0]        layerPixel [LAYERS];

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      s1Von_q   <= 1'b0;
      s1Hsync_q <= SYNC_IDLE;
      s1Vsync_q <= SYNC_IDLE;
      s1Color_q <= '0;
      s1Valid_q <= '0;
      s1Mode_q  <= '0;
    end else begin
      s1Von_q   <= von;
      s1Hsync_q <= hsync;
      s1Vsync_q <= vsync;
      s1Color_q <= layer_color;
      s1Valid_q <= layer_valid;
      s1Mode_q  <= layer_mode;
    end
  end

  // Counts refresh pulses per half-period; the counter never exceeds BLINK_FRAMES-1.
  always_comb begin
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (refresh) begin
      if (blinkCnt_q == CNT_LAST) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b1;
    end else begin
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  always_comb begin
    for (int i = 0; i < LAYERS; i++) begin
      layerEffective[i] = s1Valid_q[i]
                          && (s1Mode_q[2*i +: 2] != MODE_DISABLE)
                          && !((s1Mode_q[2*i +: 2] == MODE_BLINK) && !blinkPhase_q);
      layerPixel[i]     = (s1Mode_q[2*i +: 2] == MODE_INVERT)
                          ? ~s1Color_q[i*COLOR_W +: COLOR_W]
                          :  s1Color_q[i*COLOR_W +: COLOR_W];
    end
  end

  // Walk from lowest to highest priority so the lowest-index effective layer wins.
  always_comb begin
    outColor_d = BG_COLOR;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (layerEffective[i]) begin
        outColor_d = layerPixel[i];
      end
    end
    if (!s1Von_q) begin
      outColor_d = '0;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      outColor_q <= '0;
      outHsync_q <= SYNC_IDLE;
      outVsync_q <= SYNC_IDLE;
      outVon_q   <= 1'b0;
    end else begin
      outColor_q <= outColor_d;
      outHsync_q <= s1Hsync_q;
      outVsync_q <= s1Vsync_q;
      outVon_q   <= s1Von_q;
    end
  end

  assign out_color   = outColor_q;
  assign HSYNC       = outHsync_q;
  assign VSYNC       = outVsync_q;
  assign out_von     = outVon_q;
  assign blink_phase = blinkPhase_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Self-checking bench for vga_layer_mixer: directed scenarios plus randomized pixels,
// compared every cycle against a two-deep expected-output queue driven by plain rules.
module tb_vga_layer_mixer;

  localparam int         LAYERS  = 4;
  localparam int         COLOR_W = 8;
  localparam int         BF      = 2;
  localparam logic [7:0] BG      = 8'h49;

  logic        mclk = 1'b0;
  logic        reset;
  logic        von;
  logic        hsync;
  logic        vsync;
  logic        refresh;
  logic [31:0] layerColor;
  logic [3:0]  layerValid;
  logic [7:0]  layerMode;
  logic [7:0]  out_color;
  logic        HSYNC;
  logic        VSYNC;
  logic        out_von;
  logic        blink_phase;

  int checkCount = 0;
  int failCount  = 0;
  bit checkEn    = 1'b0;

  logic [7:0] curColor  = 8'h00;
  logic       curVon    = 1'b0;
  logic       curH      = 1'b1;
  logic       curV      = 1'b1;
  logic [7:0] pendColor = 8'h00;
  logic       pendVon   = 1'b0;
  logic       pendH     = 1'b1;
  logic       pendV     = 1'b1;
  int         nRef      = 0;

  vga_layer_mixer #(
    .LAYERS(LAYERS),
    .COLOR_W(COLOR_W),
    .BLINK_FRAMES(BF)
  ) dut (
    .mclk(mclk),
    .reset(reset),
    .von(von),
    .hsync(hsync),
    .vsync(vsync),
    .refresh(refresh),
    .layer_color(layerColor),
    .layer_valid(layerValid),
    .layer_mode(layerMode),
    .out_color(out_color),
    .HSYNC(HSYNC),
    .VSYNC(VSYNC),
    .out_von(out_von),
    .blink_phase(blink_phase)
  );

  always #5 mclk = ~mclk;

  function automatic logic [7:0] modelPixel(input logic v, input logic [31:0] col,
                                            input logic [3:0] vld, input logic [7:0] md,
                                            input logic phase);
    if (!v) return 8'h00;
    for (int i = 0; i < LAYERS; i++) begin
      logic [1:0] m;
      logic [7:0] c;
      m = md[2*i +: 2];
      c = col[8*i +: 8];
      if (vld[i] && m != 2'd3 && !(m == 2'd2 && !phase))
        return (m == 2'd1) ? ~c : c;
    end
    return BG;
  endfunction

  function automatic logic modelPhase(input int refreshes);
    return ((refreshes / BF) % 2) == 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic hs, input logic vs, input logic rf,
                               input logic [31:0] col, input logic [3:0] vld, input logic [7:0] md);
    @(posedge mclk);
    #1;
    von        = v;
    hsync      = hs;
    vsync      = vs;
    refresh    = rf;
    layerColor = col;
    layerValid = vld;
    layerMode  = md;
  endtask

  task automatic waitOutput();
    repeat (2) @(posedge mclk);
    @(negedge mclk);
  endtask

  // Expected outputs lag the sampled inputs by one extra register; reset clears both slots.
  initial begin
    forever begin
      @(posedge mclk or posedge reset);
      if (reset) begin
        curColor = 8'h00; curVon = 1'b0; curH = 1'b1; curV = 1'b1;
        pendColor = 8'h00; pendVon = 1'b0; pendH = 1'b1; pendV = 1'b1;
        nRef = 0;
      end else begin
        curColor = pendColor; curVon = pendVon; curH = pendH; curV = pendV;
        if (refresh) nRef++;
        pendColor = modelPixel(von, layerColor, layerValid, layerMode, modelPhase(nRef));
        pendVon   = von;
        pendH     = hsync;
        pendV     = vsync;
      end
    end
  end

  initial begin
    forever begin
      @(negedge mclk);
      if (checkEn) begin
        checkOutput("model out_color", out_color, curColor);
        checkOutput("model out_von", out_von, curVon);
        checkOutput("model HSYNC", HSYNC, curH);
        checkOutput("model VSYNC", VSYNC, curV);
        checkOutput("model blink_phase", blink_phase, modelPhase(nRef));
      end
    end
  end

  initial begin
    int firstLow, lowCount, firstVonHigh, firstHighAfter;
    reset = 1'b1; von = 1'b0; hsync = 1'b1; vsync = 1'b1; refresh = 1'b0;
    layerColor = '0; layerValid = '0; layerMode = '0;
    checkEn = 1'b1;
    @(negedge mclk);
    checkOutput("reset out_color", out_color, 8'h00);
    checkOutput("reset HSYNC", HSYNC, 1'b1);
    checkOutput("reset blink_phase", blink_phase, 1'b1);
    repeat (2) @(posedge mclk);
    #1 reset = 1'b0;

    applyStimulus(1, 1, 1, 0, 32'h00FF_E300, 4'b0110, 8'h00);
    waitOutput();
    checkOutput("priority L1", out_color, 8'hE3);
    applyStimulus(1, 1, 1, 0, 32'h00FF_E300, 4'b0000, 8'h00);
    waitOutput();
    checkOutput("background", out_color, 8'h49);
    applyStimulus(1, 1, 1, 0, 32'h0000_00C1, 4'b0001, 8'b00_00_00_01);
    waitOutput();
    checkOutput("invert L0", out_color, 8'h3E);
    applyStimulus(1, 1, 1, 0, 32'h3D00_00C1, 4'b1001, 8'b00_00_00_11);
    waitOutput();
    checkOutput("disable L0", out_color, 8'h3D);

    applyStimulus(1, 1, 1, 0, 32'h0000_00C1, 4'b0001, 8'b00_00_00_10);
    waitOutput();
    checkOutput("blink visible", out_color, 8'hC1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, 1, 1, 32'h0000_00C1, 4'b0001, 8'b00_00_00_10);
      applyStimulus(1, 1, 1, 0, 32'h0000_00C1, 4'b0001, 8'b00_00_00_10);
    end
    waitOutput();
    checkOutput("blink phase off", blink_phase, 1'b0);
    checkOutput("blink hidden", out_color, 8'h49);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, 1, 1, 32'h0000_00C1, 4'b0001, 8'b00_00_00_10);
      applyStimulus(1, 1, 1, 0, 32'h0000_00C1, 4'b0001, 8'b00_00_00_10);
    end
    waitOutput();
    checkOutput("blink phase on", blink_phase, 1'b1);
    checkOutput("blink back", out_color, 8'hC1);

    applyStimulus(0, 1, 1, 0, 32'hA5B6_C7D8, 4'b1111, 8'h00);
    @(posedge mclk); @(negedge mclk);
    checkOutput("blank not early", out_von, 1'b1);
    @(posedge mclk); @(negedge mclk);
    checkOutput("blank color", out_color, 8'h00);
    checkOutput("blank von", out_von, 1'b0);

    applyStimulus(1, 1, 1, 0, 32'hA5B6_C7D8, 4'b1111, 8'h00);
    waitOutput();
    firstLow = -1; lowCount = 0; firstVonHigh = -1; firstHighAfter = -1;
    for (int i = 0; i < 110; i++) begin
      @(posedge mclk);
      #1;
      hsync = (i < 96) ? 1'b0 : 1'b1;
      von   = (i < 96) ? 1'b0 : 1'b1;
      @(negedge mclk);
      if (HSYNC == 1'b0) begin
        lowCount++;
        if (firstLow < 0) firstLow = i;
      end else if (firstLow >= 0 && firstHighAfter < 0) begin
        firstHighAfter = i;
      end
      if (out_von == 1'b1 && firstLow >= 0 && firstVonHigh < 0) firstVonHigh = i;
    end
    checkOutput("hsync first low", firstLow, 2);
    checkOutput("hsync low length", lowCount, 96);
    checkOutput("hsync rise", firstHighAfter, 98);
    checkOutput("von rise aligned", firstVonHigh, 98);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0,
                    $urandom_range(0, 31) != 0, $urandom_range(0, 5) == 0,
                    $urandom, 4'($urandom), 8'($urandom));
    end

    applyStimulus(1, 0, 0, 0, 32'h0000_005A, 4'b0001, 8'h00);
    waitOutput();
    checkOutput("pre-reset pixel", out_color, 8'h5A);
    @(posedge mclk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async out_color", out_color, 8'h00);
    checkOutput("async out_von", out_von, 1'b0);
    checkOutput("async HSYNC", HSYNC, 1'b1);
    checkOutput("async VSYNC", VSYNC, 1'b1);
    checkOutput("async blink_phase", blink_phase, 1'b1);
    @(posedge mclk);
    #1 reset = 1'b0;
    @(negedge mclk);
    checkOutput("release cycle0", out_color, 8'h00);
    @(posedge mclk); @(negedge mclk);
    checkOutput("release cycle1", out_color, 8'h00);
    checkOutput("release cycle1 HSYNC", HSYNC, 1'b1);
    @(posedge mclk); @(negedge mclk);
    checkOutput("release cycle2", out_color, 8'h5A);
    checkOutput("release cycle2 HSYNC", HSYNC, 1'b0);
    checkOutput("release blink_phase", blink_phase, 1'b1);

    repeat (3) @(posedge mclk);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
